// File: rtl/tiny_seq_buffer.sv
// Single-port sequence buffer: captures a stream of words, then plays it back once or in a loop.
// All state, including the playback outputs, is registered on the rising edge of clk.
module tiny_seq_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              stop,
    input  logic              hold,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic [ADDR_W-1:0] address_out,
    output logic              busy,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned     DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);

    localparam logic [1:0] ModeCapture  = 2'b01;
    localparam logic [1:0] ModePlayOnce = 2'b10;
    localparam logic [1:0] ModePlayLoop = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StPlay
    } state_e;

    state_e              state_q;
    logic                loop_q;
    logic [ADDR_W:0]     wr_ptr_q;
    logic [ADDR_W:0]     rd_ptr_q;
    logic [ADDR_W:0]     count_q;
    logic [DATA_W-1:0]   data_out_q;
    logic [ADDR_W-1:0]   address_out_q;
    logic                out_valid_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_en;
    logic                last_word;

    // Storage has no reset so that contents survive rst and a new capture start.
    always_comb begin
        wr_en = (state_q == StCapture) && in_valid && !stop && !rst;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= data_in;
        end
    end

    always_comb begin
        last_word = (rd_ptr_q == (count_q - ONE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            loop_q        <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            data_out_q    <= '0;
            address_out_q <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // stop in the same cycle as start suppresses the command.
                    if (start && !stop) begin
                        unique case (mode)
                            ModeCapture: begin
                                count_q  <= '0;
                                wr_ptr_q <= '0;
                                state_q  <= StCapture;
                            end
                            ModePlayOnce, ModePlayLoop: begin
                                rd_ptr_q <= '0;
                                loop_q   <= mode[0];
                                if (count_q != '0) begin
                                    state_q <= StPlay;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                StCapture: begin
                    if (stop) begin
                        state_q <= StIdle;
                    end else if (in_valid) begin
                        address_out_q <= wr_ptr_q[ADDR_W-1:0];
                        wr_ptr_q      <= wr_ptr_q + ONE;
                        count_q       <= count_q + ONE;
                        if (wr_ptr_q == (DEPTH_CNT - ONE)) begin
                            state_q <= StIdle;
                        end
                    end
                end

                StPlay: begin
                    if (stop) begin
                        state_q <= StIdle;
                    end else if (!hold) begin
                        data_out_q    <= mem[rd_ptr_q[ADDR_W-1:0]];
                        address_out_q <= rd_ptr_q[ADDR_W-1:0];
                        out_valid_q   <= 1'b1;
                        if (last_word && loop_q) begin
                            rd_ptr_q <= '0;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + ONE;
                        end
                        // The final word is still presented while the FSM is already idle.
                        if (last_word && !loop_q) begin
                            state_q <= StIdle;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign data_out    = data_out_q;
    assign out_valid   = out_valid_q;
    assign address_out = address_out_q;
    assign busy        = (state_q != StIdle);
    assign count       = count_q;

endmodule

// File: tb/tb_tiny_seq_buffer.sv
// Directed bench for tiny_seq_buffer: stimulus pushes expected playback words into a queue,
// a negedge monitor pops and compares every out_valid beat.
module tb_tiny_seq_buffer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] data_in = '0;
    logic              in_valid = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              hold = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic [ADDR_W-1:0] address_out;
    logic              busy;
    logic [ADDR_W:0]   count;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int mon_e;

    tiny_seq_buffer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .mode       (mode),
        .start      (start),
        .stop       (stop),
        .hold       (hold),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .address_out(address_out),
        .busy       (busy),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    task automatic capture_word(input int d, input int idx);
        in_valid = 1'b1;
        data_in  = DATA_W'(d);
        tick();
        in_valid = 1'b0;
        check("cap_addr", int'(address_out), idx);
        check("cap_count", int'(count), idx + 1);
    endtask

    task automatic play_word(input int addr, input int d);
        exp_q.push_back((addr << 8) | d);
        tick();
    endtask

    // Monitor: every out_valid beat must match the next queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_valid: got addr %0d data 0x%0h expected none",
                             address_out, data_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("play_data", int'(data_out), mon_e & 255);
                    check("play_addr", int'(address_out), mon_e >> 8);
                end
            end
        end
    end

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(count), 0);
        check("rst_address", int'(address_out), 0);
        check("rst_data", int'(data_out), 0);

        // Capture three words with gaps; a start while busy is ignored.
        pulse_start(2'b01);
        check("cap_busy", int'(busy), 1);
        check("cap_count0", int'(count), 0);
        capture_word(8'hA1, 0);
        tick();
        capture_word(8'hB2, 1);
        tick();
        tick();
        pulse_start(2'b11);
        check("cap_busy_after_start", int'(busy), 1);
        capture_word(8'hC3, 2);
        tick();
        check("cap_stays_busy", int'(busy), 1);
        check("cap_count3", int'(count), 3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", int'(busy), 0);
        check("stop_count", int'(count), 3);

        // Play once: A1,B2,C3 then idle.
        pulse_start(2'b10);
        check("play_busy", int'(busy), 1);
        play_word(0, 8'hA1);
        play_word(1, 8'hB2);
        play_word(2, 8'hC3);
        check("once_busy_fall", int'(busy), 0);
        check("once_last_valid", int'(out_valid), 1);
        tick();
        check("once_valid_low", int'(out_valid), 0);

        // Fill all 16 locations; auto-return to idle, extra in_valid ignored.
        pulse_start(2'b01);
        for (int i = 0; i < 16; i++) capture_word(i, i);
        check("full_busy", int'(busy), 0);
        check("full_count", int'(count), 16);
        in_valid = 1'b1;
        data_in  = 8'hEE;
        tick();
        in_valid = 1'b0;
        check("extra_count", int'(count), 16);
        check("extra_busy", int'(busy), 0);

        // Loop playback wraps ...0F,00,01.
        pulse_start(2'b11);
        for (int k = 0; k < 18; k++) play_word(k % 16, k % 16);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("loop_stop_busy", int'(busy), 0);
        check("loop_stop_valid", int'(out_valid), 0);

        // Hold for two cycles mid-stream.
        pulse_start(2'b11);
        for (int k = 0; k < 4; k++) play_word(k, k);
        hold = 1'b1;
        for (int h = 0; h < 2; h++) begin
            tick();
            check("hold_valid", int'(out_valid), 0);
            check("hold_addr", int'(address_out), 3);
            check("hold_data", int'(data_out), 3);
        end
        hold = 1'b0;
        for (int k = 4; k < 8; k++) play_word(k, k);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Reset in the middle of loop playback at address 5.
        pulse_start(2'b11);
        for (int k = 0; k < 6; k++) play_word(k, k);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_count", int'(count), 0);
        check("midrst_addr", int'(address_out), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_data", int'(data_out), 0);

        // stop together with start in idle: nothing begins.
        stop  = 1'b1;
        start = 1'b1;
        mode  = 2'b01;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        check("stop_start_busy", int'(busy), 0);
        tick();
        check("stop_start_busy2", int'(busy), 0);

        // Play with an empty buffer never leaves idle.
        pulse_start(2'b10);
        check("empty_once_busy", int'(busy), 0);
        pulse_start(2'b11);
        check("empty_loop_busy", int'(busy), 0);
        tick();
        tick();
        check("empty_valid", int'(out_valid), 0);

        tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
